// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register command path:
// op codes, sequencer state encoding and a small op-class helper.
package usr_pkg;

  localparam logic [2:0] USR_SISO = 3'd0;
  localparam logic [2:0] USR_SIPO = 3'd1;
  localparam logic [2:0] USR_PIPO = 3'd2;
  localparam logic [2:0] USR_PISO = 3'd3;
  localparam logic [2:0] USR_ROL  = 3'd4;
  localparam logic [2:0] USR_ROR  = 3'd5;
  localparam logic [2:0] USR_LS   = 3'd6;
  localparam logic [2:0] USR_RS   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DONE  = 3'd4
  } usr_state_e;

  // Ops 0..3 need a load cycle before they act; 4..7 act on the register contents directly.
  function automatic logic op_needs_load(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/usr_sin_serializer.sv
// Holds the captured operand and walks a bit index over it, LSB first,
// exposing the current bit, the following bit and a registered last-bit flag.
module usr_sin_serializer
  import usr_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_capture,
  input  logic [n-1:0] i_data,
  input  logic         i_advance,
  output logic         o_bit,
  output logic         o_next_bit,
  output logic         o_last
);

  localparam int CNT_W = $clog2(n + 1);
  localparam logic [CNT_W-1:0] PRE_LAST_IDX = CNT_W'(n - 2);

  logic [n-1:0]     r_operand;
  logic [CNT_W-1:0] r_count;
  logic             r_last;
  logic [n-1:0]     w_sel_cur;
  logic [n-1:0]     w_sel_next;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_operand <= '0;
      r_count   <= '0;
      r_last    <= 1'b0;
    end else if (i_capture) begin
      r_operand <= i_data;
      r_count   <= '0;
      r_last    <= 1'b0;
    end else if (i_advance && !r_last) begin
      r_count <= r_count + 1'b1;
      r_last  <= (r_count == PRE_LAST_IDX);
    end
  end

  // One-hot bit pickers keep the index compare width-exact for any n.
  for (genvar gi = 0; gi < n; gi++) begin : g_pick
    assign w_sel_cur[gi] = (r_count == CNT_W'(gi));
    if (gi == 0) begin : g_first
      assign w_sel_next[gi] = 1'b0;
    end else begin : g_rest
      assign w_sel_next[gi] = (r_count == CNT_W'(gi - 1));
    end
  end

  assign o_bit      = |(r_operand & w_sel_cur);
  assign o_next_bit = |(r_operand & w_sel_next);
  assign o_last     = r_last;

endmodule

// File: rtl/usr_op_sequencer.sv
// Command stage for the universal shift register: accepts one op per handshake
// and plays out the sel/ctrl/pin/sin cycle sequence that op needs, then pulses done.
module usr_op_sequencer
  import usr_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic [2:0]   i_req_op,
  input  logic [n-1:0] i_req_data,
  input  logic         i_abort,
  output logic [2:0]   o_usr_sel,
  output logic         o_usr_ctrl,
  output logic [n-1:0] o_usr_pin,
  output logic         o_usr_sin,
  output logic         o_busy,
  output logic         o_done,
  output logic [2:0]   o_done_op
);

  usr_state_e   r_state;
  logic [2:0]   r_op;
  logic [2:0]   r_sel;
  logic         r_ctrl;
  logic [n-1:0] r_pin;
  logic         r_sin;
  logic         r_busy;
  logic         r_done;
  logic [2:0]   r_done_op;

  logic w_accept;
  logic w_advance;
  logic w_bit;
  logic w_next_bit;
  logic w_last;

  assign o_req_ready = (r_state == ST_IDLE) && !i_abort;
  assign w_accept    = o_req_ready && i_req_valid;
  assign w_advance   = (r_state == ST_SHIFT) && !i_abort && !w_last;

  usr_sin_serializer #(.n(n)) u_ser (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_capture  (w_accept),
    .i_data     (i_req_data),
    .i_advance  (w_advance),
    .o_bit      (w_bit),
    .o_next_bit (w_next_bit),
    .o_last     (w_last)
  );

  // Every branch starts from the idle output values; only live-op transitions override them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_op      <= '0;
      r_sel     <= '0;
      r_ctrl    <= 1'b0;
      r_pin     <= '0;
      r_sin     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_op <= '0;
    end else begin
      r_ctrl    <= 1'b0;
      r_pin     <= '0;
      r_sin     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_op <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op   <= i_req_op;
            r_sel  <= i_req_op;
            r_pin  <= i_req_data;
            r_busy <= 1'b1;
            r_state <= op_needs_load(i_req_op) ? ST_LOAD : ST_EXEC;
          end
        end
        ST_LOAD: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
          end else begin
            r_ctrl <= 1'b1;
            r_pin  <= r_pin;
            r_busy <= 1'b1;
            if (r_op == USR_PIPO) begin
              r_state <= ST_EXEC;
            end else begin
              r_sin   <= w_bit;
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
          end else if (w_last) begin
            r_busy    <= 1'b1;
            r_done    <= 1'b1;
            r_done_op <= r_op;
            r_state   <= ST_DONE;
          end else begin
            r_ctrl <= 1'b1;
            r_pin  <= r_pin;
            r_sin  <= w_next_bit;
            r_busy <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
          end else begin
            r_busy    <= 1'b1;
            r_done    <= 1'b1;
            r_done_op <= r_op;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_usr_sel  = r_sel;
  assign o_usr_ctrl = r_ctrl;
  assign o_usr_pin  = r_pin;
  assign o_usr_sin  = r_sin;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_done_op  = r_done_op;

endmodule

// File: tb/tb_usr_op_sequencer.sv
// Bench for usr_op_sequencer: a per-op cycle-schedule model checked every cycle,
// plus directed cases with hand-computed literal expectations.
module tb_usr_op_sequencer;
  import usr_pkg::*;

  localparam int N = 4;
  localparam int K_IDLE = 0, K_LOAD = 1, K_SHIFT = 2, K_EXEC = 3, K_DONE = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_op = '0;
  logic [N-1:0] req_data = '0;
  logic         abort = 1'b0;
  logic [2:0]   usr_sel;
  logic         usr_ctrl;
  logic [N-1:0] usr_pin;
  logic         usr_sin;
  logic         busy;
  logic         done;
  logic [2:0]   done_op;

  int n_checks = 0;
  int n_errors = 0;

  usr_op_sequencer #(.n(N)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_op    (req_op),
    .i_req_data  (req_data),
    .i_abort     (abort),
    .o_usr_sel   (usr_sel),
    .o_usr_ctrl  (usr_ctrl),
    .o_usr_pin   (usr_pin),
    .o_usr_sin   (usr_sin),
    .o_busy      (busy),
    .o_done      (done),
    .o_done_op   (done_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           kind;
    logic [2:0]   sel;
    logic         ctrl;
    logic [N-1:0] pin;
    logic         sin;
    logic         busy;
    logic         done;
    logic [2:0]   dop;
  } exp_t;

  exp_t       sched[$];
  exp_t       cur;
  logic [2:0] sel_last = '0;

  function automatic exp_t mk(input int kind, input logic [2:0] sel, input logic ctrl,
                              input logic [N-1:0] pin, input logic sin, input logic bsy,
                              input logic dn, input logic [2:0] dop);
    exp_t e;
    e.kind = kind; e.sel = sel; e.ctrl = ctrl; e.pin = pin;
    e.sin = sin; e.busy = bsy; e.done = dn; e.dop = dop;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-op expected trace, one entry per cycle after the accepting edge.
  task automatic build(input logic [2:0] op, input logic [N-1:0] d);
    if (op < 3'd4) sched.push_back(mk(K_LOAD, op, 1'b0, d, 1'b0, 1'b1, 1'b0, 3'd0));
    if (op == USR_SISO || op == USR_SIPO || op == USR_PISO)
      for (int k = 0; k < N; k++) sched.push_back(mk(K_SHIFT, op, 1'b1, d, d[k], 1'b1, 1'b0, 3'd0));
    if (op == USR_PIPO) sched.push_back(mk(K_EXEC, op, 1'b1, d, 1'b0, 1'b1, 1'b0, 3'd0));
    if (op >= 3'd4) sched.push_back(mk(K_EXEC, op, 1'b0, d, 1'b0, 1'b1, 1'b0, 3'd0));
    sched.push_back(mk(K_DONE, op, 1'b0, '0, 1'b0, 1'b1, 1'b1, op));
  endtask

  task automatic model_reset();
    sched.delete();
    sel_last = '0;
    cur = mk(K_IDLE, 3'd0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    if (abort && cur.kind != K_IDLE && cur.kind != K_DONE) sched.delete();
    else if (cur.kind == K_IDLE && req_valid && !abort) build(req_op, req_data);
    if (sched.size() > 0) cur = sched.pop_front();
    else cur = mk(K_IDLE, sel_last, 1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0);
    sel_last = cur.sel;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("sel", 32'(usr_sel), 32'(cur.sel));
      check("ctrl", 32'(usr_ctrl), 32'(cur.ctrl));
      check("pin", 32'(usr_pin), 32'(cur.pin));
      check("sin", 32'(usr_sin), 32'(cur.sin));
      check("busy", 32'(busy), 32'(cur.busy));
      check("done", 32'(done), 32'(cur.done));
      check("done_op", 32'(done_op), 32'(cur.dop));
      check("req_ready", 32'(req_ready), 32'((cur.kind == K_IDLE) && !abort));
    end
  end

  logic q_ctrl[$];
  logic q_sin[$];

  task automatic run_op(input logic [2:0] op, input logic [N-1:0] d, input int exp_lat, input string tag);
    int w;
    int lat;
    q_ctrl.delete();
    q_sin.delete();
    req_valid = 1'b1; req_op = op; req_data = d;
    w = 0;
    while (!req_ready && w < 20) begin tick(); w++; end
    check({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    req_data = N'($urandom);
    lat = 1;
    while (lat < 40) begin
      q_ctrl.push_back(usr_ctrl);
      q_sin.push_back(usr_sin);
      if (done) break;
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_done_op"}, 32'(done_op), 32'(op));
  endtask

  initial begin
    logic [N-1:0] sbits;
    logic [2:0]   cpat;
    int           acc[3];
    logic [2:0]   t6_ops[3];
    logic [2:0]   dq[$];
    int           idx;
    int           c;

    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("reset_sel", 32'(usr_sel), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ready", 32'(req_ready), 32'd1);
    tick();

    // T2: sipo 1011 -> sin 1,1,0,1 over the four shift cycles, done 6 cycles after accept
    run_op(USR_SIPO, 4'b1011, 6, "t2_sipo");
    for (int k = 0; k < N; k++) sbits[k] = (q_sin.size() > k + 1) ? q_sin[k + 1] : 1'bx;
    check("t2_sin_bits", 32'(sbits), 32'h0000000b);
    check("t2_load_ctrl", 32'(q_ctrl[0]), 32'd0);
    tick();

    // T3: pipo A -> ctrl 0,1,0 and done 3 cycles after accept
    run_op(USR_PIPO, 4'hA, 3, "t3_pipo");
    cpat = {q_ctrl[0], q_ctrl[1], q_ctrl[2]};
    check("t3_ctrl_pattern", 32'(cpat), 32'h2);
    tick();

    // T4: rol -> single EXEC cycle with ctrl 0, done 2 cycles after accept
    run_op(USR_ROL, 4'b1001, 2, "t4_rol");
    check("t4_exec_ctrl", 32'(q_ctrl[0]), 32'd0);
    tick();

    // T5: abort during the second shift cycle of piso
    req_valid = 1'b1; req_op = USR_PISO; req_data = 4'b0110;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ctrl", 32'(usr_ctrl), 32'd0);
    check("t5_ready_abort", 32'(req_ready), 32'd0);
    abort = 1'b0;
    #1;
    check("t5_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < N + 2; k++) begin
      check("t5_no_done", 32'(done), 32'd0);
      tick();
    end

    // T6: request held through busy periods; three ops queued back to back
    t6_ops[0] = USR_PIPO; t6_ops[1] = USR_ROL; t6_ops[2] = USR_SISO;
    idx = 0; c = 0;
    req_valid = 1'b1; req_op = t6_ops[0]; req_data = N'($urandom);
    while (idx < 3 && c < 60) begin
      if (req_ready) begin acc[idx] = c; idx++; end
      tick();
      c++;
      if (done) dq.push_back(done_op);
      if (idx < 3) req_op = t6_ops[idx];
      req_data = N'($urandom);
    end
    req_valid = 1'b0;
    check("t6_all_accepted", 32'(idx), 32'd3);
    c = 0;
    while (dq.size() < 3 && c < 40) begin
      tick();
      c++;
      if (done) dq.push_back(done_op);
    end
    check("t6_gap_pipo", 32'(acc[1] - acc[0]), 32'd4);
    check("t6_gap_rol", 32'(acc[2] - acc[1]), 32'd3);
    check("t6_done_count", 32'(dq.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      check("t6_done_order", 32'((dq.size() > k) ? dq[k] : 3'd7 ^ t6_ops[k]), 32'(t6_ops[k]));

    // T1: asynchronous reset in the middle of a shift
    req_valid = 1'b1; req_op = USR_SIPO; req_data = 4'b1111;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("t1_sel", 32'(usr_sel), 32'd0);
    check("t1_ctrl", 32'(usr_ctrl), 32'd0);
    check("t1_pin", 32'(usr_pin), 32'd0);
    check("t1_sin", 32'(usr_sin), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_done", 32'(done), 32'd0);
    check("t1_done_op", 32'(done_op), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("t1_ready", 32'(req_ready), 32'd1);

    // Random traffic with occasional aborts, checked every cycle against the schedule model
    for (int i = 0; i < 1500; i++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_op    = 3'($urandom_range(0, 7));
      req_data  = N'($urandom);
      abort     = ($urandom_range(0, 15) == 0);
      tick();
    end
    req_valid = 1'b0;
    abort = 1'b0;
    repeat (N + 6) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
